// File: rtl/case_mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package case_mux_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam logic [7:0] DEFAULT_OUT_C = 8'hFF;

    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/case_mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_pick
    import case_mux_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SEL_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [SEL_W-1:0] i_rr_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_pick_idx
);
    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [SEL_W:0]    w_sum;

    assign w_req2 = {i_req, i_req};
    assign w_rot  = NREQ'(w_req2 >> i_rr_ptr);
    assign o_any  = |i_req;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_rot[k]) w_sum = {1'b0, i_rr_ptr} + (SEL_W+1)'(k);
        if (w_sum > (SEL_W+1)'(NREQ - 1))
            w_sum = w_sum - (SEL_W+1)'(NREQ);
        o_pick_idx = w_sum[SEL_W-1:0];
    end
endmodule

// File: rtl/case_mux_rr_arbiter.sv
// Round-robin arbiter driving a shared registered mux output with bounded hold.
module case_mux_rr_arbiter
    import case_mux_arb_pkg::*;
#(
    parameter int                NREQ        = 4,
    parameter int                SEL_W       = 2,
    parameter int                DATA_W      = 8,
    parameter int                MAX_HOLD    = 4,
    parameter logic [DATA_W-1:0] DEFAULT_OUT = DATA_W'(DEFAULT_OUT_C)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*DATA_W-1:0] i_req_data,
    output logic [NREQ-1:0]        o_gnt,
    output logic [SEL_W-1:0]       o_sel,
    output logic [DATA_W-1:0]      o_out,
    output logic                   o_out_valid
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        r_state, w_state_nx;
    logic [NREQ-1:0]   r_gnt, w_gnt_nx;
    logic [SEL_W-1:0]  r_sel, w_sel_nx;
    logic [DATA_W-1:0] r_out, w_out_nx;
    logic              r_out_valid, w_valid_nx;
    logic [SEL_W-1:0]  r_rr_ptr, w_ptr_nx;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nx;

    logic [SEL_W-1:0]  w_owner, w_next_ptr, w_pick_ptr, w_pick_idx;
    logic [NREQ-1:0]   w_pick_oh;
    logic              w_any, w_release;

    assign w_owner    = SEL_W'(onehot_to_idx(32'(r_gnt)));
    assign w_next_ptr = (w_owner == SEL_W'(NREQ - 1)) ? '0 : w_owner + 1'b1;
    // While granted, the only pick that matters is the release re-pick, which
    // must already see the advanced pointer.
    assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_rr_ptr;
    assign w_pick_oh  = NREQ'(1) << w_pick_idx;

    rr_pick #(.NREQ(NREQ), .SEL_W(SEL_W)) u_pick (
        .i_req      (i_req),
        .i_rr_ptr   (w_pick_ptr),
        .o_any      (w_any),
        .o_pick_idx (w_pick_idx)
    );

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_sel_nx   = r_sel;
        w_out_nx   = DEFAULT_OUT;
        w_valid_nx = 1'b0;
        w_ptr_nx   = r_rr_ptr;
        w_hold_nx  = r_hold_cnt;
        w_release  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = GRANT;
                    w_gnt_nx   = w_pick_oh;
                    w_sel_nx   = w_pick_idx;
                    w_hold_nx  = '0;
                end
            end
            GRANT: begin
                if (i_req[w_owner]) begin
                    w_out_nx   = i_req_data[int'(w_owner)*DATA_W +: DATA_W];
                    w_valid_nx = 1'b1;
                    if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) w_release = 1'b1;
                    else                                     w_hold_nx = r_hold_cnt + 1'b1;
                end else begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_ptr_nx  = w_next_ptr;
                    w_hold_nx = '0;
                    if (w_any) begin
                        w_gnt_nx = w_pick_oh;
                        w_sel_nx = w_pick_idx;
                    end else begin
                        w_gnt_nx   = '0;
                        w_sel_nx   = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_out       <= DEFAULT_OUT;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_gnt       <= w_gnt_nx;
            r_sel       <= w_sel_nx;
            r_out       <= w_out_nx;
            r_out_valid <= w_valid_nx;
            r_rr_ptr    <= w_ptr_nx;
            r_hold_cnt  <= w_hold_nx;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
endmodule
